// File: rtl/crc8_serial_engine.sv
// ---------------------------------------------------------------------------
// crc8_serial_engine
//
// Bit-serial CRC-8 engine. It takes one data bit per cycle over a valid/ready
// stream and folds it into an 8-bit LFSR, MSB-first. On the last bit of a
// frame it shows the CRC and the frame bit-length to the downstream consumer.
// It holds them until that consumer accepts them.
//
// Optional feature macro: CRC8_CHECK_EN adds a crc_match output. This output
// flags frames whose CRC residue is zero, so a frame with its CRC appended
// checks itself.
//
// Parameters:
//   POLY   generator polynomial, x^8 term implicit
//   INIT   CRC register value at reset and at the start of every frame
//   LEN_W  width of the saturating frame bit-length counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream bit valid
//   in_ready   engine can accept a bit this cycle (registered)
//   in_bit     data bit, MSB-first
//   in_last    final bit of the frame, qualified by in_valid
//   crc_valid  result available (registered)
//   crc_ready  downstream accepts the result
//   crc_out    CRC of the completed frame, held after the handshake
//   frame_len  bit count of the completed frame, saturating
//   crc_match  (CRC8_CHECK_EN only) final CRC was 8'h00
// ---------------------------------------------------------------------------
module crc8_serial_engine #(
    parameter logic [7:0]  POLY  = 8'h07,
    parameter logic [7:0]  INIT  = 8'h00,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             crc_valid,
    input  logic             crc_ready,
    output logic [7:0]       crc_out,
    output logic [LEN_W-1:0] frame_len
`ifdef CRC8_CHECK_EN
    ,
    output logic             crc_match
`endif
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e             state_q, state_d;
    logic [7:0]         crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic               xfer;
    logic               fb;
    logic [7:0]         crc_step;
    logic [LEN_W-1:0]   len_step;
    logic               capture;
    logic               in_ready_d;
    logic               crc_valid_d;

    // A transfer can only happen outside StDone, because in_ready is low there.
    assign xfer    = in_valid && in_ready;
    assign capture = xfer && in_last;

    // One LFSR step and the saturating length increment for the current bit.
    assign fb       = crc_q[7] ^ in_bit;
    assign crc_step = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    assign len_step = (&len_q) ? len_q : len_q + {{(LEN_W-1){1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (xfer) begin
                    state_d = in_last ? StDone : StAccum;
                end
            end
            StDone: begin
                if (crc_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode. It is computed from the next state and then registered,
    // so in_ready and crc_valid come straight from flops.
    always_comb begin
        in_ready_d  = (state_d != StDone);
        crc_valid_d = (state_d == StDone);
    end

    // Datapath next-state. The LFSR and counter are rearmed when the result is
    // accepted, so every frame starts from INIT and zero.
    always_comb begin
        crc_d = crc_q;
        len_d = len_q;
        if (xfer) begin
            crc_d = crc_step;
            len_d = len_step;
        end else if (state_q == StDone && crc_ready) begin
            crc_d = INIT;
            len_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q     <= INIT;
            len_q     <= '0;
            in_ready  <= 1'b1;
            crc_valid <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            len_q     <= len_d;
            in_ready  <= in_ready_d;
            crc_valid <= crc_valid_d;
        end
    end

    // Result registers take the post-update value of the in_last transfer and
    // keep it until the next frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_out   <= INIT;
            frame_len <= '0;
        end else if (capture) begin
            crc_out   <= crc_step;
            frame_len <= len_step;
        end
    end

`ifdef CRC8_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_match <= 1'b0;
        end else if (capture) begin
            crc_match <= (crc_step == 8'h00);
        end
    end
`endif

endmodule

// File: tb/tb_crc8_serial_engine.sv
// ---------------------------------------------------------------------------
// tb_crc8_serial_engine
//
// Self-checking bench for crc8_serial_engine. Two instances share all inputs:
// dut_a uses the default LEN_W=16 and dut_b uses LEN_W=4 to exercise length
// saturation. Expected results are pushed to a scoreboard queue when a frame
// is driven, then popped and compared when the result appears.
// ---------------------------------------------------------------------------
module tb_crc8_serial_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_last = 1'b0;
    logic        crc_ready = 1'b0;

    logic        in_ready_a, crc_valid_a;
    logic [7:0]  crc_out_a;
    logic [15:0] frame_len_a;
    logic        in_ready_b, crc_valid_b;
    logic [7:0]  crc_out_b;
    logic [3:0]  frame_len_b;
`ifdef CRC8_CHECK_EN
    logic        crc_match_a, crc_match_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc8_serial_engine #(.POLY(8'h07), .INIT(8'h00), .LEN_W(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .crc_valid (crc_valid_a),
        .crc_ready (crc_ready),
        .crc_out   (crc_out_a),
        .frame_len (frame_len_a)
`ifdef CRC8_CHECK_EN
        ,
        .crc_match (crc_match_a)
`endif
    );

    crc8_serial_engine #(.POLY(8'h07), .INIT(8'h00), .LEN_W(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .crc_valid (crc_valid_b),
        .crc_ready (crc_ready),
        .crc_out   (crc_out_b),
        .frame_len (frame_len_b)
`ifdef CRC8_CHECK_EN
        ,
        .crc_match (crc_match_b)
`endif
    );

    typedef struct {
        logic [31:0] data;
        int          nbits;
        bit          gaps;
        logic [7:0]  exp_crc;
    } vec_t;

    typedef struct {
        logic [7:0] crc;
        int         len;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    // Bitwise reference: MSB-first, x^8+x^2+x+1, zero init.
    function automatic logic [7:0] crc_model(logic [31:0] d, int n);
        logic [7:0] c = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left on a negedge. Bits are presented on a negedge and
    // transfer on the following posedge while in_ready is high.
    task automatic send_frame(logic [31:0] d, int n, bit gaps, bit mark_last);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (gaps) begin
                in_valid = 1'b0;
                in_bit   = ~d[n-1-i];
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_bit   = d[n-1-i];
            in_last  = mark_last && (i == n - 1);
            while (!in_ready_a && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t == 50) begin
                checks++;
                errors++;
                $display("FAIL in_ready timeout: got 0 expected 1");
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (mark_last) sb.push_back('{crc: crc_model(d, n), len: n});
    endtask

    // Called on the negedge right after the in_last transfer.
    task automatic wait_result(logic [7:0] spec_crc, int hold);
        exp_t e;
        int   t = 0;
        chk("scoreboard nonempty", (sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("crc_valid latency", crc_valid_a, 1'b1);
        while (!crc_valid_a && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("crc_out vs model", crc_out_a, e.crc);
        chk("crc_out vs spec", crc_out_a, spec_crc);
        chk("frame_len", frame_len_a, e.len);
        chk("frame_len sat", frame_len_b, (e.len > 15) ? 15 : e.len);
        chk("crc_out lenw4", crc_out_b, e.crc);
        chk("in_ready in done", in_ready_a, 1'b0);
`ifdef CRC8_CHECK_EN
        chk("crc_match", crc_match_a, (e.crc == 8'h00));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold crc_valid", crc_valid_a, 1'b1);
            chk("hold in_ready", in_ready_a, 1'b0);
            chk("hold crc_out", crc_out_a, e.crc);
            chk("hold frame_len", frame_len_a, e.len);
        end
        crc_ready = 1'b1;
        @(negedge clk);
        crc_ready = 1'b0;
        chk("post-accept crc_valid", crc_valid_a, 1'b0);
        chk("post-accept in_ready", in_ready_a, 1'b1);
        chk("post-accept crc_out held", crc_out_a, e.crc);
        chk("post-accept frame_len held", frame_len_a, e.len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 32'h01,    nbits: 8,  gaps: 1'b0, exp_crc: 8'h07};
        vecs[1] = '{data: 32'hFF,    nbits: 8,  gaps: 1'b1, exp_crc: 8'hF3};
        vecs[2] = '{data: 32'h00,    nbits: 8,  gaps: 1'b0, exp_crc: 8'h00};
        vecs[3] = '{data: 32'hABCDE, nbits: 20, gaps: 1'b0, exp_crc: crc_model(32'hABCDE, 20)};
        vecs[4] = '{data: 32'h0107,  nbits: 16, gaps: 1'b0, exp_crc: 8'h00};
        vecs[5] = '{data: 32'h0106,  nbits: 16, gaps: 1'b1, exp_crc: crc_model(32'h0106, 16)};

        #1 rst_n = 1'b0;
        #1;
        chk("reset in_ready", in_ready_a, 1'b1);
        chk("reset crc_valid", crc_valid_a, 1'b0);
        chk("reset crc_out", crc_out_a, 8'h00);
        chk("reset frame_len", frame_len_a, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // crc_ready with no result pending must be ignored.
        crc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        crc_ready = 1'b0;
        chk("idle crc_ready ignored", crc_valid_a, 1'b0);
        chk("idle in_ready", in_ready_a, 1'b1);

        foreach (vecs[k]) begin
            send_frame(vecs[k].data, vecs[k].nbits, vecs[k].gaps, 1'b1);
            wait_result(vecs[k].exp_crc, 0);
        end

        // Reset after 4 bits of a frame discards it and clears outputs.
        send_frame(32'hA, 4, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset crc_out", crc_out_a, 8'h00);
        chk("async reset frame_len", frame_len_a, 16'd0);
        chk("async reset crc_valid", crc_valid_a, 1'b0);
        chk("async reset in_ready", in_ready_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(32'h01, 8, 1'b0, 1'b1);
        wait_result(8'h07, 0);

        // Single-bit frame, result held for 5 cycles of backpressure.
        send_frame(32'h1, 1, 1'b0, 1'b1);
        wait_result(8'h07, 5);
        send_frame(32'h00, 8, 1'b0, 1'b1);
        wait_result(8'h00, 0);

        chk("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
